sram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares port 0 (read/write) of one 32x512 sky130 OpenRAM macro between a core-side master (m0) and a second bus master such as a DMA or loader (m1). Each master sees an OBI-style req/gnt/rvalid interface. The arbiter drives the macro's registered port-0 pins and returns read data one cycle after grant. It sits between the core-local interconnect and the SRAM instance; port 1 of the macro is outside this block.

---
 rtl/sram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing port 0 of a single-port-usable SRAM macro between
// two OBI-style masters; grant is combinational, responses return one cycle later.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [31:0]           m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [NUM_WMASKS-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [31:0]           m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [NUM_WMASKS-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

    logic prio_q, prio_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_id_q, rsp_id_d;
    logic rsp_we_q, rsp_we_d;

    logic gnt0, gnt1, any_gnt, win_id;
    logic                  win_we;
    logic [NUM_WMASKS-1:0] win_be;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [ADDR_WIDTH-1:0] win_waddr;

    // Gated by rst_ni so no grant (and no SRAM access) leaks out while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign win_id   = gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_comb begin
        win_we    = m0_we_i;
        win_be    = m0_be_i;
        win_wdata = m0_wdata_i;
        win_waddr = m0_addr_i[ADDR_WIDTH+1:2];
        if (win_id) begin
            win_we    = m1_we_i;
            win_be    = m1_be_i;
            win_wdata = m1_wdata_i;
            win_waddr = m1_addr_i[ADDR_WIDTH+1:2];
        end
    end

    assign sram_csb0_o  = ~any_gnt;
    assign sram_web0_o  = ~(any_gnt & win_we);
    assign sram_addr0_o = any_gnt ? win_waddr : '0;

    // Idle cycles park mask and data at zero to keep the macro pins quiet.
    for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_byte_lane
        assign sram_wmask0_o[gi]       = any_gnt & (~win_we | win_be[gi]);
        assign sram_din0_o[gi*8 +: 8]  = any_gnt ? win_wdata[gi*8 +: 8] : 8'h00;
    end

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = any_gnt;
        rsp_id_d    = win_id;
        rsp_we_d    = any_gnt & win_we;
        if (any_gnt) begin
            prio_d = ~win_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign m0_rvalid_o = rsp_valid_q & ~rsp_id_q;
    assign m1_rvalid_o = rsp_valid_q &  rsp_id_q;
    assign m0_rdata_o  = (m0_rvalid_o && !rsp_we_q) ? sram_dout0_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && !rsp_we_q) ? sram_dout0_i : '0;

    // Byte-offset and upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr_i[31:ADDR_WIDTH+2], m0_addr_i[1:0],
                                m1_addr_i[31:ADDR_WIDTH+2], m1_addr_i[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM macro plus a transaction-level
// reference (grant rule, word memory, expected response) checked every cycle.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rdata),
        .sram_csb0_o(sram_csb), .sram_web0_o(sram_web), .sram_wmask0_o(sram_wmask),
        .sram_addr0_o(sram_addr), .sram_din0_o(sram_din), .sram_dout0_i(sram_dout)
    );

    // Macro model: pins registered at posedge, access performed at the next negedge.
    logic [31:0] sram_mem [512];
    logic        s_csb = 1'b1, s_web = 1'b1;
    logic [3:0]  s_wmask = '0;
    logic [8:0]  s_addr = '0;
    logic [31:0] s_din = '0;

    always @(posedge clk) begin
        s_csb   <= sram_csb;
        s_web   <= sram_web;
        s_wmask <= sram_wmask;
        s_addr  <= sram_addr;
        s_din   <= sram_din;
    end

    always @(negedge clk) begin
        if (!s_csb) begin
            if (!s_web) begin
                for (int b = 0; b < 4; b++)
                    if (s_wmask[b]) sram_mem[s_addr][8*b +: 8] <= s_din[8*b +: 8];
            end else begin
                sram_dout <= sram_mem[s_addr];
            end
        end
    end

    // Reference: who wins, what memory holds, and what each master must see next cycle.
    logic [31:0] ref_mem [512];
    logic        ref_prio = 1'b0;
    logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    logic [1:0]  ref_g;

    always_comb begin
        ref_g = 2'b00;
        if (rst_n) begin
            if (m0_req && m1_req) ref_g = ref_prio ? 2'b10 : 2'b01;
            else if (m0_req)      ref_g = 2'b01;
            else if (m1_req)      ref_g = 2'b10;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_prio <= 1'b0;
            exp_rv0  <= 1'b0;
            exp_rv1  <= 1'b0;
            exp_rd0  <= '0;
            exp_rd1  <= '0;
        end else begin
            exp_rv0 <= ref_g[0];
            exp_rv1 <= ref_g[1];
            exp_rd0 <= (ref_g[0] && !m0_we) ? ref_mem[m0_addr[10:2]] : 32'h0;
            exp_rd1 <= (ref_g[1] && !m1_we) ? ref_mem[m1_addr[10:2]] : 32'h0;
            if (ref_g[0] && m0_we)
                for (int b = 0; b < 4; b++)
                    if (m0_be[b]) ref_mem[m0_addr[10:2]][8*b +: 8] <= m0_wdata[8*b +: 8];
            if (ref_g[1] && m1_we)
                for (int b = 0; b < 4; b++)
                    if (m1_be[b]) ref_mem[m1_addr[10:2]][8*b +: 8] <= m1_wdata[8*b +: 8];
            if (ref_g != 2'b00) ref_prio <= ref_g[0];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h4;
        tick(); tick();
        total++;
        if ({m0_gnt, m1_gnt, m0_rv, m1_rv} !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt_rv got=%b want=0000", {m0_gnt, m1_gnt, m0_rv, m1_rv});
        end
        total++;
        if ({sram_csb, sram_web} !== 2'b11) begin
            bad++; $display("FAIL reset_csb_web got=%b want=11", {sram_csb, sram_web});
        end
        total++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", m0_rdata, m1_rdata);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            bad++; $display("FAIL reset_first_tie got=%b want=10", {m0_gnt, m1_gnt});
        end
        $display("reset: released, first tie gnt m0=%b m1=%b", m0_gnt, m1_gnt);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_be = 4'hF; m0_wdata = 32'hDEADBEEF;
        #1;
        total++;
        if (m0_gnt !== 1'b1 || sram_addr !== 9'h10 || sram_web !== 1'b0 || sram_wmask !== 4'hF) begin
            bad++; $display("FAIL wr_drive got gnt=%b addr=%h web=%b mask=%h want 1/010/0/f",
                            m0_gnt, sram_addr, sram_web, sram_wmask);
        end
        tick();
        total++;
        if (m0_rv !== 1'b1 || m0_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_resp got rv=%b rdata=%h want 1/0", m0_rv, m0_rdata);
        end
        m0_we = 1'b0; m0_wdata = 32'h0;
        #1;
        total++;
        if (m0_gnt !== 1'b1 || sram_addr !== 9'h10 || sram_web !== 1'b1 || sram_wmask !== 4'hF) begin
            bad++; $display("FAIL rd_drive got gnt=%b addr=%h web=%b mask=%h want 1/010/1/f",
                            m0_gnt, sram_addr, sram_web, sram_wmask);
        end
        tick();
        m0_req = 1'b0;
        total++;
        if (m0_rv !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_resp got rv=%b rdata=%h want 1/deadbeef", m0_rv, m0_rdata);
        end
        $display("write_read: m0 0x40 read back %h", m0_rdata);
        tick();
    endtask

    task automatic test_byte_mask();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_be = 4'hF; m1_wdata = 32'hFFFFFFFF;
        tick();
        m1_be = 4'h5; m1_wdata = 32'h0;
        tick();
        m1_we = 1'b0;
        tick();
        m1_req = 1'b0;
        total++;
        if (m1_rv !== 1'b1 || m1_rdata !== 32'hFF00FF00) begin
            bad++; $display("FAIL byte_mask got rv=%b rdata=%h want 1/ff00ff00", m1_rv, m1_rdata);
        end
        $display("byte_mask: m1 0x8 read back %h", m1_rdata);
        tick();
    endtask

    task automatic test_contention();
        logic e0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin m0_req = 1'b0; m1_req = 1'b0; end
            #1;
            if (i < 6) begin
                e0 = (i % 2 == 0);
                total++;
                if (m0_gnt !== e0 || m1_gnt !== !e0) begin
                    bad++; $display("FAIL contend_gnt[%0d] got=%b%b want=%b%b", i, m0_gnt, m1_gnt, e0, !e0);
                end
            end
            if (i > 0) begin
                total++;
                if (m0_rv !== (i % 2 == 1) || m1_rv !== (i % 2 == 0)) begin
                    bad++; $display("FAIL contend_rv[%0d] got=%b%b want=%b%b", i, m0_rv, m1_rv,
                                    (i % 2 == 1), (i % 2 == 0));
                end
                total++;
                if ((m0_rv && m0_rdata !== 32'hDEADBEEF) || (m1_rv && m1_rdata !== 32'hFF00FF00)) begin
                    bad++; $display("FAIL contend_rdata[%0d] got=%h/%h want=deadbeef/ff00ff00", i, m0_rdata, m1_rdata);
                end
            end
            $display("contention[%0d]: gnt=%b%b rv=%b%b", i, m0_gnt, m1_gnt, m0_rv, m1_rv);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1FC; m1_be = 4'hF; m1_wdata = 32'h12345678;
        #1;
        total++;
        if (m1_gnt !== 1'b1) begin
            bad++; $display("FAIL b2b_wgnt got=%b want=1", m1_gnt);
        end
        tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1FC;
        #1;
        total++;
        if (m0_gnt !== 1'b1 || sram_addr !== 9'h7F || m1_rv !== 1'b1 || m1_rdata !== 32'h0) begin
            bad++; $display("FAIL b2b_overlap got gnt0=%b addr=%h rv1=%b rd1=%h want 1/07f/1/0",
                            m0_gnt, sram_addr, m1_rv, m1_rdata);
        end
        tick();
        m0_req = 1'b0;
        total++;
        if (m0_rv !== 1'b1 || m0_rdata !== 32'h12345678) begin
            bad++; $display("FAIL b2b_read got rv=%b rdata=%h want 1/12345678", m0_rv, m0_rdata);
        end
        $display("back_to_back: m0 read of 0x1fc = %h", m0_rdata);
        tick();
    endtask

    task automatic test_mid_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        #1;
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++; $display("FAIL midrst_gnt got=%b want=1", m0_gnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        total++;
        if (m0_rv !== 1'b0 || m0_rdata !== 32'h0 || sram_csb !== 1'b1) begin
            bad++; $display("FAIL midrst_in got rv=%b rdata=%h csb=%b want 0/0/1", m0_rv, m0_rdata, sram_csb);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (m0_rv !== 1'b0 || m1_rv !== 1'b0) begin
            bad++; $display("FAIL midrst_after got rv=%b%b want=00", m0_rv, m1_rv);
        end
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        #1;
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            bad++; $display("FAIL midrst_tie got=%b want=10", {m0_gnt, m1_gnt});
        end
        $display("mid_reset: post-release tie gnt=%b%b", m0_gnt, m1_gnt);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic g0 = 1'b1, g1 = 1'b1;
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            if (!m0_req || g0) begin
                m0_req = ($urandom_range(0, 3) != 0);
                m0_we = $urandom_range(0, 1) == 1;
                r = $urandom;
                m0_addr = (r & 32'hFFFF_F803) | (32'($urandom_range(0, 15)) << 2);
                m0_be = 4'($urandom_range(0, 15));
                m0_wdata = $urandom;
            end
            if (!m1_req || g1) begin
                m1_req = ($urandom_range(0, 3) != 0);
                m1_we = $urandom_range(0, 1) == 1;
                r = $urandom;
                m1_addr = (r & 32'hFFFF_F803) | (32'($urandom_range(0, 15)) << 2);
                m1_be = 4'($urandom_range(0, 15));
                m1_wdata = $urandom;
            end
            #1;
            total++;
            if ({m1_gnt, m0_gnt} !== ref_g || sram_csb !== (ref_g == 2'b00)) begin
                bad++; $display("FAIL rand_gnt[%0d] got=%b%b csb=%b want=%b", i, m1_gnt, m0_gnt, sram_csb, ref_g);
            end
            total++;
            if (m0_rv !== exp_rv0 || m1_rv !== exp_rv1 || m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                bad++; $display("FAIL rand_rsp[%0d] got rv=%b%b rd=%h/%h want rv=%b%b rd=%h/%h", i,
                                m0_rv, m1_rv, m0_rdata, m1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            $display("random[%0d]: req=%b%b gnt=%b%b rv=%b%b", i, m0_req, m1_req, m0_gnt, m1_gnt, m0_rv, m1_rv);
            g0 = ref_g[0];
            g1 = ref_g[1];
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_contention();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
